ssd_scan_driver: RTL and testbench
==================================

// Module: ssd_scan_driver
// PURPOSE
//   Parametrised multiplexed seven-segment driver for the Nexys A7 display bank.
//   Time-multiplexes NUM_DIGITS hex digits onto shared cathodes with per-digit enable,
//   per-digit decimal point, leading-zero blanking and PWM brightness.
//   Inputs are double-buffered and committed only at frame boundaries, so displays never tear.
//   Instantiated in vga_top between game/score logic and the An*/Ca..Dp pins.
// PARAMETERS
//   NUM_DIGITS    8    number of multiplexed digits (1..8)
//   CLK_DIV_BITS  18   digit slot = 2^CLK_DIV_BITS ClkPort cycles; must be >= BRIGHT_BITS
//   BRIGHT_BITS   4    brightness control width
//   ACTIVE_LOW    1    1: anodes/cathodes asserted low (Nexys A7); 0: asserted high
// PORTS
//   ClkPort     in   1              system clock (100 MHz)
//   Reset       in   1              asynchronous, active-high reset
//   value       in   4*NUM_DIGITS   hex nibbles; digit i = value[4i+3:4i]; digit 0 rightmost
//   dp_in       in   NUM_DIGITS     1 = decimal point of digit i lit
//   digit_en    in   NUM_DIGITS     1 = digit i may be driven; 0 = blank
//   lz_blank    in   1              1 = blank leading zero digits
//   brightness  in   BRIGHT_BITS    PWM duty: on-fraction = (brightness+1)/2^BRIGHT_BITS
//   load        in   1              pulse: request commit of value/dp_in/digit_en/lz_blank
//   anodes      out  NUM_DIGITS     digit select, one-hot when active
//   cathodes    out  8              {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}
//   frame_done  out  1              1-cycle pulse when digit index wraps to 0
// BEHAVIOUR
//   Reset (async): prescaler=0, digit index=0, load_pending=0, shadows (value, dp, en, lz)=0,
//     anodes=all inactive, cathodes=all inactive (8'hFF if ACTIVE_LOW), frame_done=0.
//   Prescaler: CLK_DIV_BITS-bit up counter, free-running. At all-ones it wraps and the index
//     advances; index wraps NUM_DIGITS-1 -> 0 (non-power-of-2 counts wrap explicitly).
//   Frame boundary = cycle the index goes NUM_DIGITS-1 -> 0; frame_done is registered high
//     for exactly that one cycle.
//   load: sets sticky load_pending. At a frame boundary with load_pending (or load high that
//     same cycle), the shadows capture inputs and load_pending clears. A load on the boundary
//     cycle commits immediately. Display uses shadows only; input changes mid-frame are invisible.
//   Leading-zero blanking (shadow lz=1): digit i>0 blanked if nibbles NUM_DIGITS-1 .. i are all 0.
//     Digit 0 never LZ-blanked. The dp bit of an LZ-blanked digit is also suppressed.
//   PWM: slot top bits t = prescaler[CLK_DIV_BITS-1 -: BRIGHT_BITS]; anode on when t <= brightness.
//     brightness is not shadowed (takes effect next cycle). Max value = 100% duty.
//   Digit driven = index in range && shadow en[index] && !lz-blanked && PWM on; otherwise all
//     anodes inactive and cathodes inactive.
//   Segment map (active-high abcdefg): 0=1111110 1=0110000 2=1101101 3=1111001 4=0110011
//     5=1011011 6=1011111 7=1110000 8=1111111 9=1111011 A=1110111 b=0011111 C=1001110
//     d=0111101 E=1001111 F=1000111; Dp = shadow dp[index]; all bits inverted if ACTIVE_LOW.
//   Latency: anodes/cathodes/frame_done registered; they reflect prescaler/index state 1 cycle later.
//   Reset mid-frame: outputs go inactive asynchronously; pending load is discarded.
// TESTING (NUM_DIGITS=4, CLK_DIV_BITS=4, BRIGHT_BITS=4, ACTIVE_LOW=1)
//   Assert Reset mid-run -> anodes=4'hF, cathodes=8'hFF immediately; frame_done=0; shadows cleared.
//   value=16'h1234, digit_en=4'hF, dp_in=0, brightness=15, load pulse -> after next frame_done,
//     slot 0 anodes=4'b1110 cathodes=8'b10011001 ('4'); slot 3 anodes=4'b0111 cathodes=8'b10011111 ('1').
//   value=16'h0050, lz_blank=1, load -> slots 3,2 anodes=4'hF; slot 1 shows '5' (8'b01001001);
//     slot 0 shows '0' (8'b00000011).
//   brightness=3 -> each enabled slot drives its anode for exactly 4 of 16 cycles
//     (prescaler 0..3, seen one cycle later); brightness=0 -> 1 of 16 cycles.
//   load pulse mid-frame with new value 16'hABCD -> outputs unchanged until the frame boundary;
//     frame_done pulses 1 cycle; next slot 0 shows 'D' (8'b10000101).
//   load asserted on the exact boundary cycle -> committed that boundary; digit_en=4'b0101
//     -> slots 1,3 anodes stay 4'hF all frame.

Source files
------------

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver
//   Multiplexed seven-segment scan driver for the Nexys A7 display bank.
//   It time-multiplexes NUM_DIGITS hex digits onto a shared cathode bus. Each
//   digit has its own enable and decimal point. The driver also provides
//   leading-zero blanking and PWM brightness control.
//   value, dp_in, digit_en and lz_blank are captured into shadow registers only
//   at a frame boundary. A frame is never drawn from two different input sets,
//   so the display does not tear.
//
// Ports
//   ClkPort     in   clock
//   Reset       in   asynchronous, active-high reset
//   value       in   4*NUM_DIGITS hex nibbles, digit 0 rightmost
//   dp_in       in   per-digit decimal point (1 = lit)
//   digit_en    in   per-digit enable (0 = blank)
//   lz_blank    in   1 = blank leading zero digits (digit 0 is never blanked)
//   brightness  in   PWM duty, on-fraction = (brightness+1)/2^BRIGHT_BITS
//   load        in   request commit of value/dp_in/digit_en/lz_blank
//   anodes      out  digit select, one-hot when a digit is driven
//   cathodes    out  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}
//   frame_done  out  1-cycle pulse after the digit index wraps to 0
module ssd_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int CLK_DIV_BITS = 18,
  parameter int BRIGHT_BITS  = 4,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                      ClkPort,
  input  logic                      Reset,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic                      lz_blank,
  input  logic [BRIGHT_BITS-1:0]    brightness,
  input  logic                      load,
  output logic [NUM_DIGITS-1:0]     anodes,
  output logic [7:0]                cathodes,
  output logic                      frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CLK_DIV_BITS-1:0] PRESC_MAX = '1;
  // Inactive levels of the output pins.
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [7:0]            CA_OFF = {8{ACTIVE_LOW}};

  genvar gi;

  logic [CLK_DIV_BITS-1:0]  presc_reg, presc_next;
  logic [IDX_W-1:0]         idx_reg, idx_next;
  logic                     load_pending_reg, load_pending_next;
  logic [4*NUM_DIGITS-1:0]  sh_value_reg;
  logic [NUM_DIGITS-1:0]    sh_dp_reg, sh_en_reg;
  logic                     sh_lz_reg;
  logic [NUM_DIGITS-1:0]    anodes_reg, anodes_next;
  logic [7:0]               cathodes_reg, cathodes_next;
  logic                     frame_done_reg;

  logic                     slot_end, frame_wrap, commit;
  logic [NUM_DIGITS-1:0]    lit;
  logic [7:0]               pat [NUM_DIGITS];
  logic [NUM_DIGITS:1]      zero_from;
  logic [7:0]               sel_pat;
  logic                     sel_lit;
  logic                     pwm_on;
  logic [BRIGHT_BITS-1:0]   slot_phase;
  logic [NUM_DIGITS-1:0]    onehot;

  // Active-high abcdefg pattern for one hex nibble.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0: seg7 = 7'b1111110;
      4'h1: seg7 = 7'b0110000;
      4'h2: seg7 = 7'b1101101;
      4'h3: seg7 = 7'b1111001;
      4'h4: seg7 = 7'b0110011;
      4'h5: seg7 = 7'b1011011;
      4'h6: seg7 = 7'b1011111;
      4'h7: seg7 = 7'b1110000;
      4'h8: seg7 = 7'b1111111;
      4'h9: seg7 = 7'b1111011;
      4'hA: seg7 = 7'b1110111;
      4'hB: seg7 = 7'b0011111;
      4'hC: seg7 = 7'b1001110;
      4'hD: seg7 = 7'b0111101;
      4'hE: seg7 = 7'b1001111;
      default: seg7 = 7'b1000111;
    endcase
  endfunction

  assign slot_end   = (presc_reg == PRESC_MAX);
  assign frame_wrap = slot_end && (idx_reg == LAST_IDX);
  // A load arriving on the boundary cycle itself commits without waiting a frame.
  assign commit     = frame_wrap && (load_pending_reg || load);

  // Per-digit segment pattern and visibility from the shadow registers.
  // zero_from[i] = nibbles NUM_DIGITS-1 .. i are all zero.
  assign zero_from[NUM_DIGITS] = 1'b1;
  for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic [3:0] nib;
    assign nib     = sh_value_reg[4*gi +: 4];
    assign pat[gi] = {seg7(nib), sh_dp_reg[gi]};
    if (gi == 0) begin : g_first
      assign lit[gi] = sh_en_reg[gi];
    end else begin : g_rest
      if (gi < NUM_DIGITS - 1) begin : g_mid
        assign zero_from[gi] = zero_from[gi+1] && (nib == 4'd0);
      end else begin : g_top
        assign zero_from[gi] = (nib == 4'd0);
      end
      assign lit[gi] = sh_en_reg[gi] && !(sh_lz_reg && zero_from[gi]);
    end
  end

  // Pick the current digit. Index values outside 0..NUM_DIGITS-1 match no
  // digit, so they leave the display blank.
  always_comb begin
    sel_pat = '0;
    sel_lit = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        sel_pat = pat[i];
        sel_lit = lit[i];
      end
    end
  end

  assign slot_phase = presc_reg[CLK_DIV_BITS-1 -: BRIGHT_BITS];
  assign pwm_on     = (slot_phase <= brightness);
  assign onehot     = NUM_DIGITS'(1) << idx_reg;

  always_comb begin
    presc_next        = presc_reg + CLK_DIV_BITS'(1);
    idx_next          = idx_reg;
    load_pending_next = load_pending_reg | load;
    anodes_next       = AN_OFF;
    cathodes_next     = CA_OFF;
    if (slot_end) begin
      idx_next = (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);
    end
    if (frame_wrap) begin
      load_pending_next = 1'b0;
    end
    if (sel_lit && pwm_on) begin
      anodes_next   = onehot ^ AN_OFF;
      cathodes_next = sel_pat ^ CA_OFF;
    end
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      presc_reg        <= '0;
      idx_reg          <= '0;
      load_pending_reg <= 1'b0;
      sh_value_reg     <= '0;
      sh_dp_reg        <= '0;
      sh_en_reg        <= '0;
      sh_lz_reg        <= 1'b0;
      anodes_reg       <= AN_OFF;
      cathodes_reg     <= CA_OFF;
      frame_done_reg   <= 1'b0;
    end else begin
      presc_reg        <= presc_next;
      idx_reg          <= idx_next;
      load_pending_reg <= load_pending_next;
      anodes_reg       <= anodes_next;
      cathodes_reg     <= cathodes_next;
      frame_done_reg   <= frame_wrap;
      if (commit) begin
        sh_value_reg <= value;
        sh_dp_reg    <= dp_in;
        sh_en_reg    <= digit_en;
        sh_lz_reg    <= lz_blank;
      end
    end
  end

  assign anodes     = anodes_reg;
  assign cathodes   = cathodes_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver
//   Bench for ssd_scan_driver configured with 4 digits, a 16-cycle slot,
//   4-bit brightness and active-low outputs. A time-based reference model
//   predicts every output on every clock. Directed checks pin specific slots
//   against hand-derived literals.
module tb_ssd_scan_driver;

  logic        ClkPort;
  logic        Reset;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        lz_blank;
  logic [3:0]  brightness;
  logic        load;
  logic [3:0]  anodes;
  logic [7:0]  cathodes;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  ssd_scan_driver #(
    .NUM_DIGITS(4), .CLK_DIV_BITS(4), .BRIGHT_BITS(4), .ACTIVE_LOW(1'b1)
  ) dut (
    .ClkPort(ClkPort), .Reset(Reset), .value(value), .dp_in(dp_in),
    .digit_en(digit_en), .lz_blank(lz_blank), .brightness(brightness),
    .load(load), .anodes(anodes), .cathodes(cathodes), .frame_done(frame_done)
  );

  initial begin
    ClkPort = 1'b0;
    forever #5 ClkPort = ~ClkPort;
  end

  // ---------------- reference model ----------------
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  // k = cycles since the frame started (0..63). The result is {anodes, cathodes}.
  function automatic logic [11:0] model_out(input int k, input logic [15:0] v,
                                            input logic [3:0] en, input logic [3:0] dp,
                                            input logic lz, input logic [3:0] br);
    int          slot;
    int          p;
    logic [15:0] above;
    logic [7:0]  seg_on;
    slot  = k / 16;
    p     = k % 16;
    above = v >> (4 * slot);
    if (!en[slot] || (lz && slot > 0 && above == 16'd0) || p > int'(br))
      return {4'hF, 8'hFF};
    seg_on = {SEG_TAB[above[3:0]], dp[slot]};
    return {~(4'b0001 << slot), ~seg_on};
  endfunction

  int          m_k;
  logic        m_pend;
  logic [15:0] m_val;
  logic [3:0]  m_en, m_dp;
  logic        m_lz;
  logic [3:0]  exp_an;
  logic [7:0]  exp_ca;
  logic        exp_fd;
  logic [11:0] m_now;

  assign m_now = model_out(m_k, m_val, m_en, m_dp, m_lz, brightness);

  always @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      m_k    <= 0;
      m_pend <= 1'b0;
      m_val  <= '0;
      m_en   <= '0;
      m_dp   <= '0;
      m_lz   <= 1'b0;
      exp_an <= 4'hF;
      exp_ca <= 8'hFF;
      exp_fd <= 1'b0;
    end else begin
      exp_an <= m_now[11:8];
      exp_ca <= m_now[7:0];
      exp_fd <= (m_k == 63);
      m_k    <= (m_k + 1) % 64;
      if (m_k == 63) begin
        m_pend <= 1'b0;
        if (m_pend || load) begin
          m_val <= value;
          m_en  <= digit_en;
          m_dp  <= dp_in;
          m_lz  <= lz_blank;
        end
      end else if (load) begin
        m_pend <= 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model (skipped while Reset is held).
  always @(negedge ClkPort) begin
    if (!Reset) begin
      tests++;
      if (anodes !== exp_an || cathodes !== exp_ca || frame_done !== exp_fd) begin
        fails++;
        $display("FAIL model t=%0t: got an=%b ca=%b fd=%b, expected an=%b ca=%b fd=%b",
                 $time, anodes, cathodes, frame_done, exp_an, exp_ca, exp_fd);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end else begin
      $display("[TB] ok %s = %b", name, got);
    end
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge ClkPort);
  endtask

  // Returns at the negedge where frame_done is high, i.e. frame cycle 0.
  task automatic sync_frame(input string name);
    int n;
    n = 0;
    do begin
      @(negedge ClkPort);
      n++;
    end while (frame_done !== 1'b1 && n < 200);
    tests++;
    if (frame_done !== 1'b1) begin
      fails++;
      $display("FAIL %s: got no frame_done within 200 cycles, expected a pulse", name);
    end
  endtask

  task automatic pulse_load();
    load = 1'b1;
    @(negedge ClkPort);
    load = 1'b0;
  endtask

  // Counts, over one frame, the cycles in which each slot drives its anode.
  task automatic pwm_frame(input string name, input int exp0, input int exp1);
    int cnt [4];
    for (int s = 0; s < 4; s++) cnt[s] = 0;
    sync_frame({name, "_sync"});
    for (int j = 0; j < 64; j++) begin
      @(negedge ClkPort);
      if (anodes !== 4'hF) cnt[j / 16]++;
    end
    chk({name, "_slot0"}, 8'(cnt[0]), 8'(exp0));
    chk({name, "_slot1"}, 8'(cnt[1]), 8'(exp1));
    chk({name, "_slot2"}, 8'(cnt[2]), 8'd0);
    chk({name, "_slot3"}, 8'(cnt[3]), 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected a finished run");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    Reset = 1'b1; value = '0; dp_in = '0; digit_en = '0; lz_blank = 1'b0;
    brightness = 4'd15; load = 1'b0;
    skip(3);
    chk("reset_anodes", {4'h0, anodes}, 8'h0F);
    chk("reset_cathodes", cathodes, 8'hFF);
    chk("reset_frame_done", {7'd0, frame_done}, 8'd0);
    Reset = 1'b0;

    // Basic display: 1234, all digits enabled, full brightness.
    skip(5);
    value = 16'h1234; digit_en = 4'hF; dp_in = 4'h0; lz_blank = 1'b0;
    pulse_load();
    sync_frame("t1_sync");
    skip(1);
    chk("t1_slot0_an", {4'h0, anodes}, 8'h0E);
    chk("t1_slot0_ca", cathodes, 8'b10011001);
    skip(48);
    chk("t1_slot3_an", {4'h0, anodes}, 8'h07);
    chk("t1_slot3_ca", cathodes, 8'b10011111);

    // Leading-zero blanking of 0050.
    value = 16'h0050; lz_blank = 1'b1;
    pulse_load();
    sync_frame("t2_sync");
    skip(1);
    chk("t2_slot0_an", {4'h0, anodes}, 8'h0E);
    chk("t2_slot0_ca", cathodes, 8'b00000011);
    skip(16);
    chk("t2_slot1_an", {4'h0, anodes}, 8'h0D);
    chk("t2_slot1_ca", cathodes, 8'b01001001);
    skip(16);
    chk("t2_slot2_an", {4'h0, anodes}, 8'h0F);
    chk("t2_slot2_ca", cathodes, 8'hFF);
    skip(16);
    chk("t2_slot3_an", {4'h0, anodes}, 8'h0F);

    // PWM duty: brightness 3 gives 4 of 16 cycles; brightness 0 gives 1 of 16.
    brightness = 4'd3;
    pwm_frame("t3_b3", 4, 4);
    brightness = 4'd0;
    pwm_frame("t3_b0", 1, 1);
    brightness = 4'd15;

    // Mid-frame load stays invisible until the boundary.
    sync_frame("t4_sync");
    skip(20);
    value = 16'hABCD; lz_blank = 1'b0;
    pulse_load();
    chk("t4_mid_slot1_ca", cathodes, 8'b01001001);
    skip(16);
    chk("t4_mid_slot2_an", {4'h0, anodes}, 8'h0F);
    sync_frame("t4_boundary");
    skip(1);
    chk("t4_fd_one_cycle", {7'd0, frame_done}, 8'd0);
    chk("t4_slot0_an", {4'h0, anodes}, 8'h0E);
    chk("t4_slot0_ca", cathodes, 8'b10000101);

    // Load asserted exactly on the boundary cycle commits that boundary.
    sync_frame("t5_sync");
    skip(63);
    value = 16'h1234; digit_en = 4'b0101; dp_in = 4'b0001;
    pulse_load();
    chk("t5_boundary_fd", {7'd0, frame_done}, 8'd1);
    skip(1);
    chk("t5_slot0_an", {4'h0, anodes}, 8'h0E);
    chk("t5_slot0_ca_dp", cathodes, 8'b10011000);
    skip(16);
    chk("t5_slot1_an", {4'h0, anodes}, 8'h0F);
    skip(16);
    chk("t5_slot2_an", {4'h0, anodes}, 8'h0B);
    chk("t5_slot2_ca", cathodes, 8'b00100101);
    skip(16);
    chk("t5_slot3_an", {4'h0, anodes}, 8'h0F);

    // Reset mid-frame with a pending load: outputs blank at once, load discarded.
    skip(5);
    load = 1'b1;
    @(negedge ClkPort);
    load = 1'b0;
    #3 Reset = 1'b1;
    #1;
    chk("t6_async_an", {4'h0, anodes}, 8'h0F);
    chk("t6_async_ca", cathodes, 8'hFF);
    chk("t6_async_fd", {7'd0, frame_done}, 8'd0);
    skip(2);
    Reset = 1'b0;
    sync_frame("t6_sync");
    skip(1);
    chk("t6_after_slot0_an", {4'h0, anodes}, 8'h0F);
    skip(32);
    chk("t6_after_slot2_an", {4'h0, anodes}, 8'h0F);

    skip(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
